// File: rtl/pmu_apb_master.sv
// APB requester for a power-management unit: serves host read/write commands
// and autonomously polls the PMU status register at a fixed period.
module pmu_apb_master #(
  parameter int         POLL_PERIOD = 1024,
  parameter int         TIMEOUT     = 16,
  parameter logic [7:0] POLL_ADDR   = 8'h04
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  input  logic        poll_enable,
  output logic [31:0] status_word,
  output logic        status_valid,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [7:0]  paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic          is_poll_q, is_poll_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic          poll_pending_q, poll_pending_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    paddr_q, paddr_d;
  logic          pwrite_q, pwrite_d;
  logic [31:0]   pwdata_q, pwdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_error_q, rsp_error_d;
  logic [31:0]   status_word_q, status_word_d;
  logic          status_valid_q, status_valid_d;
  logic          poll_wrap;
  logic          start_poll;

  assign cmd_ready    = rst_n && (state_q == ST_IDLE);
  assign psel         = (state_q != ST_IDLE);
  assign penable      = (state_q == ST_ACCESS);
  assign paddr        = paddr_q;
  assign pwrite       = pwrite_q;
  assign pwdata       = pwdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_error    = rsp_error_q;
  assign status_word  = status_word_q;
  assign status_valid = status_valid_q;

  // Next-state logic: host-first arbitration, APB phasing, timeout and poll timer
  always_comb begin
    state_d        = state_q;
    is_poll_d      = is_poll_q;
    tmo_cnt_d      = tmo_cnt_q;
    paddr_d        = paddr_q;
    pwrite_d       = pwrite_q;
    pwdata_d       = pwdata_q;
    rsp_valid_d    = 1'b0;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_error_d    = rsp_error_q;
    status_word_d  = status_word_q;
    status_valid_d = 1'b0;
    start_poll     = 1'b0;
    poll_wrap      = poll_enable && (poll_cnt_q == POLL_LAST);

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_SETUP;
          is_poll_d = 1'b0;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pwdata_d  = cmd_wdata;
        end else if (poll_pending_q) begin
          state_d    = ST_SETUP;
          is_poll_d  = 1'b1;
          paddr_d    = POLL_ADDR;
          pwrite_d   = 1'b0;
          start_poll = 1'b1;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        tmo_cnt_d = '0;
      end
      ST_ACCESS: begin
        // A late pready in the final allowed cycle still wins over the abort
        if (pready) begin
          state_d = ST_IDLE;
          if (is_poll_q) begin
            status_word_d  = prdata;
            status_valid_d = 1'b1;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b0;
            rsp_rdata_d = pwrite_q ? 32'h0 : prdata;
          end
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d = ST_IDLE;
          if (!is_poll_q) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = 32'h0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!poll_enable) begin
      poll_cnt_d     = '0;
      poll_pending_d = 1'b0;
    end else begin
      poll_cnt_d     = poll_wrap ? '0 : poll_cnt_q + PW'(1);
      poll_pending_d = (poll_pending_q && !start_poll) || poll_wrap;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      is_poll_q      <= 1'b0;
      poll_cnt_q     <= '0;
      poll_pending_q <= 1'b0;
      tmo_cnt_q      <= '0;
      paddr_q        <= '0;
      pwrite_q       <= 1'b0;
      pwdata_q       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_error_q    <= 1'b0;
      status_word_q  <= '0;
      status_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      is_poll_q      <= is_poll_d;
      poll_cnt_q     <= poll_cnt_d;
      poll_pending_q <= poll_pending_d;
      tmo_cnt_q      <= tmo_cnt_d;
      paddr_q        <= paddr_d;
      pwrite_q       <= pwrite_d;
      pwdata_q       <= pwdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_error_q    <= rsp_error_d;
      status_word_q  <= status_word_d;
      status_valid_q <= status_valid_d;
    end
  end

endmodule

// File: tb/tb_pmu_apb_master.sv
// Scoreboard bench for pmu_apb_master: an APB completer model predicts each
// response when a transfer starts, and a monitor checks responses as they appear.
module tb_pmu_apb_master;

  localparam int         POLL_PERIOD = 8;
  localparam int         TIMEOUT     = 16;
  localparam logic [7:0] POLL_ADDR   = 8'h04;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        poll_enable = 1'b0;
  logic [31:0] status_word;
  logic        status_valid;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  pmu_apb_master #(
    .POLL_PERIOD(POLL_PERIOD),
    .TIMEOUT    (TIMEOUT),
    .POLL_ADDR  (POLL_ADDR)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .poll_enable (poll_enable),
    .status_word (status_word),
    .status_valid(status_valid),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_poll;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  exp_t exp_q[$];
  cmd_t cmd_q[$];
  bit   order_log[$];

  int          n_checks = 0;
  int          n_fails = 0;
  int          force_waits = -1;
  bit          force_rd_en = 1'b0;
  logic [31:0] force_rd_val = '0;
  int          poll_count = 0;
  int          last_access_cycles = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fails++;
    $display("[TB] FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  function automatic int pick_waits();
    if ($urandom_range(0, 19) < 15) return $urandom_range(0, 3);
    return $urandom_range(TIMEOUT - 2, TIMEOUT + 1);
  endfunction

  // APB completer: decides wait states and data for each transfer and predicts
  // the outcome: error only when pready stays low for all TIMEOUT cycles
  initial begin : completer
    logic [7:0]  a;
    logic        w;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          is_poll;
    bit          done;
    int          waits;
    int          cyc;
    cmd_t        c;
    pready = 1'b0;
    prdata = '0;
    forever begin
      @(negedge clk);
      if (psel === 1'b1 && penable === 1'b0) begin
        a       = paddr;
        w       = pwrite;
        wd      = pwdata;
        is_poll = (a == POLL_ADDR) && !w;
        waits   = (force_waits >= 0) ? force_waits : pick_waits();
        rd      = w ? 32'h0 : (force_rd_en ? force_rd_val : $urandom);
        order_log.push_back(is_poll);
        if (is_poll) begin
          poll_count++;
          if (waits < TIMEOUT) exp_q.push_back('{1'b1, rd, 1'b0});
        end else begin
          if (cmd_q.size() == 0) begin
            fail_now("unexpected_host_transfer");
          end else begin
            c = cmd_q.pop_front();
            check_output("setup_paddr", {24'h0, a}, {24'h0, c.addr});
            check_output("setup_pwrite", {31'h0, w}, {31'h0, c.write});
            check_output("setup_pwdata", wd, c.wdata);
          end
          exp_q.push_back('{1'b0, (waits < TIMEOUT) ? rd : 32'h0, waits >= TIMEOUT});
        end
        @(posedge clk); #1;
        cyc  = 0;
        done = 1'b0;
        while (!done && psel === 1'b1 && penable === 1'b1 && cyc <= TIMEOUT + 2) begin
          check_output("access_paddr_stable", {24'h0, paddr}, {24'h0, a});
          check_output("access_pwrite_stable", {31'h0, pwrite}, {31'h0, w});
          check_output("access_pwdata_stable", pwdata, wd);
          pready = (cyc == waits);
          prdata = pready ? rd : $urandom;
          cyc++;
          @(posedge clk); #1;
          if (pready) done = 1'b1;
        end
        pready = 1'b0;
        last_access_cycles = cyc;
      end
    end
  end

  // Monitor: every response pulse must match the oldest prediction in order
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid === 1'b1 && status_valid === 1'b1) fail_now("rsp_status_overlap");
    if (rsp_valid === 1'b1 || status_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_response");
      end else begin
        e = exp_q.pop_front();
        check_output("response_kind_is_status", {31'h0, status_valid}, {31'h0, e.is_poll});
        if (e.is_poll) begin
          check_output("status_word", status_word, e.rdata);
        end else begin
          check_output("rsp_rdata", rsp_rdata, e.rdata);
          check_output("rsp_error", {31'h0, rsp_error}, {31'h0, e.err});
        end
        check_output("psel_low_at_response", {31'h0, psel}, 32'h0);
      end
    end
  end

  task automatic issue_cmd(input logic w, input logic [7:0] a, input logic [31:0] d);
    int waited;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (cmd_ready !== 1'b1) begin
      fail_now("cmd_accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    cmd_q.push_back('{w, a, d});
    #1 cmd_valid = 1'b0;
  endtask

  task automatic apply_stimulus();
    logic       w;
    logic [7:0] a;
    w = 1'($urandom_range(0, 1));
    a = 8'($urandom);
    if (a == POLL_ADDR) a = 8'h05;
    issue_cmd(w, a, $urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 500 && (exp_q.size() != 0 || psel !== 1'b0 || rsp_valid === 1'b1 || status_valid === 1'b1));
    if (n >= 500) fail_now("wait_idle_timeout");
  endtask

  task automatic wait_status();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 200 && status_valid !== 1'b1);
    if (status_valid !== 1'b1) fail_now("wait_status_timeout");
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int start_idx;
    int polls_before;
    int n;

    // Reset: every output low, cmd_ready held low
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_psel", {31'h0, psel}, 32'h0);
    check_output("reset_penable", {31'h0, penable}, 32'h0);
    check_output("reset_pwrite", {31'h0, pwrite}, 32'h0);
    check_output("reset_paddr", {24'h0, paddr}, 32'h0);
    check_output("reset_pwdata", pwdata, 32'h0);
    check_output("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_output("reset_rsp_rdata", rsp_rdata, 32'h0);
    check_output("reset_rsp_error", {31'h0, rsp_error}, 32'h0);
    check_output("reset_status_word", status_word, 32'h0);
    check_output("reset_status_valid", {31'h0, status_valid}, 32'h0);
    check_output("reset_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    rst_n = 1'b1;
    #1;
    check_output("post_reset_cmd_ready", {31'h0, cmd_ready}, 32'h1);

    // Zero-wait write: SETUP, one ACCESS, response at the third edge
    force_waits = 0;
    @(posedge clk); #1;
    issue_cmd(1'b1, 8'h08, 32'h5020_0C00);
    @(negedge clk);
    check_output("wr_edge1_psel", {31'h0, psel}, 32'h1);
    check_output("wr_edge1_penable", {31'h0, penable}, 32'h0);
    check_output("wr_edge1_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    @(negedge clk);
    check_output("wr_edge2_penable", {31'h0, penable}, 32'h1);
    check_output("wr_edge2_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check_output("wr_edge3_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    check_output("wr_edge3_rsp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    check_output("wr_rsp_one_cycle", {31'h0, rsp_valid}, 32'h0);
    wait_idle();

    // Read with two wait states
    force_waits  = 2;
    force_rd_en  = 1'b1;
    force_rd_val = 32'h0000_0ABC;
    @(posedge clk); #1;
    issue_cmd(1'b0, 8'h10, 32'h0);
    wait_idle();
    check_output("rd_wait_access_cycles", 32'(last_access_cycles), 32'd3);
    force_rd_en = 1'b0;

    // Timeout boundary: no pready in 16 cycles aborts, pready in cycle 16 completes
    force_waits = TIMEOUT;
    @(posedge clk); #1;
    issue_cmd(1'b0, 8'h14, 32'h0);
    wait_idle();
    check_output("timeout_access_cycles", 32'(last_access_cycles), 32'(TIMEOUT));
    force_waits = TIMEOUT - 1;
    @(posedge clk); #1;
    issue_cmd(1'b0, 8'h18, 32'h0);
    wait_idle();
    check_output("late_ready_access_cycles", 32'(last_access_cycles), 32'(TIMEOUT));

    // Host command present when the poll becomes pending: host goes first
    force_waits = 0;
    start_idx = order_log.size();
    @(posedge clk); #1;
    poll_enable = 1'b1;
    repeat (POLL_PERIOD) @(posedge clk);
    #1;
    issue_cmd(1'b0, 8'h20, 32'h0);
    wait_status();
    poll_enable = 1'b0;
    wait_idle();
    if (order_log.size() >= start_idx + 2) begin
      check_output("arb_first_is_host", {31'h0, order_log[start_idx]}, 32'h0);
      check_output("arb_second_is_poll", {31'h0, order_log[start_idx + 1]}, 32'h1);
    end else begin
      fail_now("arb_transfers_missing");
    end

    // Disable polling during a poll's ACCESS phase
    force_waits = 4;
    @(posedge clk); #1;
    poll_enable = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (n < 100 && !(psel === 1'b1 && penable === 1'b1 && paddr == POLL_ADDR));
    if (n >= 100) fail_now("poll_access_not_seen");
    poll_enable = 1'b0;
    wait_status();
    polls_before = poll_count;
    repeat (3 * POLL_PERIOD) @(negedge clk);
    check_output("no_polls_when_disabled", 32'(poll_count), 32'(polls_before));

    // Re-enable: the restarted timer must produce its poll exactly one period later
    force_waits = 0;
    @(posedge clk); #1;
    poll_enable = 1'b1;
    repeat (POLL_PERIOD) @(posedge clk);
    @(negedge clk);
    check_output("poll_not_early", {31'h0, psel}, 32'h0);
    @(negedge clk);
    check_output("poll_starts_after_period", {31'h0, psel}, 32'h1);
    check_output("poll_addr", {24'h0, paddr}, {24'h0, POLL_ADDR});
    check_output("poll_cmd_ready_low", {31'h0, cmd_ready}, 32'h0);
    wait_status();
    poll_enable = 1'b0;
    wait_idle();

    // Reset during a host read ACCESS: bus released, no response
    force_waits = 10;
    @(posedge clk); #1;
    issue_cmd(1'b0, 8'h30, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_output("rst_mid_psel", {31'h0, psel}, 32'h0);
    check_output("rst_mid_penable", {31'h0, penable}, 32'h0);
    check_output("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check_output("rst_mid_paddr", {24'h0, paddr}, 32'h0);
    check_output("rst_mid_status_word", status_word, 32'h0);
    exp_q.delete();
    cmd_q.delete();
    rst_n = 1'b1;
    force_waits = -1;
    repeat (3) @(negedge clk);
    check_output("rst_mid_no_late_rsp", {31'h0, rsp_valid}, 32'h0);

    // Randomized host traffic mixed with autonomous polls
    poll_enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 9) == 0) poll_enable = ~poll_enable;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      apply_stimulus();
    end
    poll_enable = 1'b0;
    wait_idle();
    check_output("all_predictions_consumed", 32'(exp_q.size()), 32'h0);
    check_output("all_commands_issued", 32'(cmd_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
